// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle multiply/divide sequencer for the EX stage.
//
// Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO and owns the architectural HI/LO
// registers. Multiplies use a 32-step shift-add, divides use a 32-step
// restoring divider. Signed operations run on absolute values and fix the
// result signs at commit.
//
// Optional build macro:
//   MULDIV_FAST_MUL_EN - mult/multu use a combinational 32x32 multiplier and
//                        finish after a single BUSY cycle. Division unchanged.
//
// Ports:
//   clk, rst       clock; asynchronous active-high reset
//   flush          abort any in-flight operation, no HI/LO update
//   start, op      EX holds a muldiv-class instruction (op encoding below)
//   src1, src2     rs / rt operands
//   stallreq       hold IF..EX (combinational)
//   busy           state is BUSY
//   done           one-cycle pulse after HI/LO commit
//   hi_o, lo_o     HI / LO registers

module muldiv_ctrl #(
    parameter logic [31:0] HILO_RST_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic        stallreq,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t      state, state_nx;
    logic [5:0]  cnt;
    logic        is_div;     // in-flight op is a divide
    logic        div_zero;   // divisor was zero: acc already holds the result
    logic        neg_q;      // negate product / quotient at commit
    logic        neg_r;      // negate remainder at commit
    logic [63:0] mcand;      // multiplicand, shifts left each step
    logic [31:0] mplr;       // multiplier (shifts right) or divisor (held)
    logic [63:0] acc;        // product, or {remainder, dividend->quotient}

    logic        is_mul_op, is_div_op, is_md_op, op_signed;
    logic        accept, commit;
    logic [31:0] abs1, abs2;
    logic [32:0] div_shift, div_diff;
    logic [63:0] step_acc;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    assign is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div_op = (op == OP_DIV)  || (op == OP_DIVU);
    assign is_md_op  = is_mul_op || is_div_op;
    assign op_signed = (op == OP_MULT) || (op == OP_DIV);

    // Signed 0x8000_0000 wraps to itself; the sign fix at commit undoes it.
    assign abs1 = (op_signed && src1[31]) ? -src1 : src1;
    assign abs2 = (op_signed && src2[31]) ? -src2 : src2;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        commit   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!flush && start && is_md_op) begin
                    accept   = 1'b1;
                    state_nx = S_BUSY;
                end
            end
            S_BUSY: begin
                if (flush) begin
                    state_nx = S_IDLE;
                end else if (cnt == 6'd31) begin
                    commit   = 1'b1;
                    state_nx = S_DONE;
                end
            end
            // The frozen EX instruction still shows start here; ignore it.
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // In BUSY the stall holds through a flush cycle and drops the cycle after.
    assign stallreq = ((state == S_IDLE) && start && is_md_op && !flush) ||
                      (state == S_BUSY);
    assign busy     = (state == S_BUSY);
    assign done     = (state == S_DONE);

    // ------------------------------------------------------------------
    // One iteration step
    // ------------------------------------------------------------------
    // Remainder is always below the divisor, so the shifted remainder fits
    // in 33 bits and a non-borrowing difference fits back in 32.
    assign div_shift = acc[63:31];
    assign div_diff  = div_shift - {1'b0, mplr};

    always_comb begin
        step_acc = acc;
        if (is_div) begin
            if (!div_diff[32]) step_acc = {div_diff[31:0], acc[30:0], 1'b1};
            else               step_acc = {acc[62:0], 1'b0};
        end else if (mplr[0]) begin
            step_acc = acc + mcand;
        end
    end

    assign prod_fix = neg_q ? -step_acc : step_acc;
    assign quo_fix  = neg_q ? -step_acc[31:0]  : step_acc[31:0];
    assign rem_fix  = neg_r ? -step_acc[63:32] : step_acc[63:32];

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= 6'd0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            mcand    <= 64'd0;
            mplr     <= 32'd0;
            acc      <= 64'd0;
        end else if (accept) begin
            is_div   <= is_div_op;
            neg_q    <= op_signed && (src1[31] ^ src2[31]);
            neg_r    <= op_signed && src1[31];
            mcand    <= {32'd0, abs1};
            mplr     <= abs2;
            cnt      <= 6'd0;
            div_zero <= 1'b0;
            if (is_div_op) begin
                if (src2 == 32'd0) begin
                    // Result is known now; one BUSY cycle then commit as-is.
                    div_zero <= 1'b1;
                    cnt      <= 6'd31;
                    acc      <= {src1, 32'hFFFF_FFFF};
                end else begin
                    acc      <= {32'd0, abs1};
                end
            end else begin
`ifdef MULDIV_FAST_MUL_EN
                // Product ready now; a zero multiplier makes the BUSY step a no-op.
                acc  <= {32'd0, abs1} * {32'd0, abs2};
                mplr <= 32'd0;
                cnt  <= 6'd31;
`else
                acc  <= 64'd0;
`endif
            end
        end else if (state == S_BUSY && !flush) begin
            cnt <= cnt + 6'd1;
            acc <= step_acc;
            if (!is_div) begin
                mcand <= {mcand[62:0], 1'b0};
                mplr  <= {1'b0, mplr[31:1]};
            end
        end
    end

    // ------------------------------------------------------------------
    // HI / LO
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_o <= HILO_RST_VAL;
            lo_o <= HILO_RST_VAL;
        end else if (commit) begin
            if (div_zero) begin
                hi_o <= acc[63:32];
                lo_o <= acc[31:0];
            end else if (is_div) begin
                hi_o <= rem_fix;
                lo_o <= quo_fix;
            end else begin
                hi_o <= prod_fix[63:32];
                lo_o <= prod_fix[31:0];
            end
        end else if (state == S_IDLE && start && !flush) begin
            if (op == OP_MTHI) hi_o <= src1;
            if (op == OP_MTLO) lo_o <= src1;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;
    localparam logic [31:0] RST_VAL = 32'h0000_0000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_STALL = 2;
    localparam logic [2:0] LONG_OP = OP_DIV;   // an op still long enough to interrupt
`else
    localparam int MUL_STALL = 33;
    localparam logic [2:0] LONG_OP = OP_MULT;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, start;
    logic [2:0]  op;
    logic [31:0] src1, src2;
    logic        stallreq, busy, done;
    logic [31:0] hi_o, lo_o;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          stall;
    } exp_t;
    exp_t sb[$];

    logic [31:0] m_hi, m_lo;   // model of architectural HI/LO

    muldiv_ctrl #(.HILO_RST_VAL(RST_VAL)) dut (
        .clk(clk), .rst(rst), .flush(flush), .start(start), .op(op),
        .src1(src1), .src2(src2), .stallreq(stallreq), .busy(busy),
        .done(done), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
        logic [63:0] p;
        int da, db;
        h = m_hi; l = m_lo;
        case (o)
            OP_MULTU: begin p = {32'd0, a} * {32'd0, b}; h = p[63:32]; l = p[31:0]; end
            OP_MULT:  begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; h = p[63:32]; l = p[31:0]; end
            OP_DIVU: begin
                if (b == 0) begin h = a; l = 32'hFFFF_FFFF; end
                else begin h = a % b; l = a / b; end
            end
            OP_DIV: begin
                if (b == 0) begin h = a; l = 32'hFFFF_FFFF; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin h = 0; l = 32'h8000_0000; end
                else begin da = a; db = b; h = da % db; l = da / db; end
            end
            default: ;
        endcase
    endfunction

    function automatic int stall_for(input logic [2:0] o, input logic [31:0] b);
        if (o == OP_DIV || o == OP_DIVU) return (b == 0) ? 2 : 33;
        return MUL_STALL;
    endfunction

    // Issue one mul/div with start held until the DONE cycle, then release.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
        exp_t e;
        int n;
        model(o, a, b, e.hi, e.lo);
        e.stall = stall_for(o, b);
        sb.push_back(e);
        @(negedge clk);
        start = 1'b1; op = o; src1 = a; src2 = b;
        #1;
        n = 0;
        while (stallreq && n < 100) begin
            n++;
            @(negedge clk);
            if (n == 1) begin src1 = ~a; src2 = $urandom; end  // must be ignored
            #1;
        end
        check({tag, " done"}, done, 1'b1);
        if (sb.size() == 0) begin
            check({tag, " sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            check({tag, " stall_cycles"}, n, e.stall);
            check({tag, " hi"}, hi_o, e.hi);
            check({tag, " lo"}, lo_o, e.lo);
            m_hi = e.hi; m_lo = e.lo;
        end
        @(negedge clk); #1;
        check({tag, " no_reissue"}, busy, 1'b0);
        check({tag, " done_pulse"}, done, 1'b0);
        start = 1'b0; #1;
        check({tag, " stall_idle"}, stallreq, 1'b0);
    endtask

    initial begin
        logic saw_done;
        logic [2:0] ro;
        rst = 1'b1; flush = 1'b0; start = 1'b0; op = 3'd0; src1 = 0; src2 = 0;
        m_hi = RST_VAL; m_lo = RST_VAL;
        #12;
        check("rst hi", hi_o, RST_VAL);
        check("rst lo", lo_o, RST_VAL);
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst stall", stallreq, 1'b0);
        @(negedge clk); rst = 1'b0;

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        run_op(OP_MULT,  32'hFFFF_FFFD, 32'd5,         "mult_neg");
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         "div_neg");
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(OP_DIVU,  32'h0000_1234, 32'd0,         "divu_zero");
        run_op(OP_DIV,   32'hFFFF_FFFB, 32'd0,         "div_zero_sgn");
        run_op(OP_DIVU,  32'hFFFF_FFFF, 32'd7,         "divu_big");
        for (int i = 0; i < 6; i++) begin
            ro = 3'($urandom_range(1, 4));
            run_op(ro, $urandom, (i == 5) ? 32'd3 : $urandom, "rand");
        end

        // unused op codes are no-ops
        @(negedge clk); start = 1'b1; op = 3'b111; #1;
        check("noop stall", stallreq, 1'b0);
        @(negedge clk); start = 1'b0; #1;
        check("noop busy", busy, 1'b0);

        // mtlo
        @(negedge clk); start = 1'b1; op = OP_MTLO; src1 = 32'h5555_1234; #1;
        check("mtlo stall", stallreq, 1'b0);
        m_lo = 32'h5555_1234;
        @(negedge clk); start = 1'b0; #1;
        check("mtlo lo", lo_o, m_lo);

        // mthi, back-to-back long op, flushed at cnt == 10
        @(negedge clk); start = 1'b1; op = OP_MTHI; src1 = 32'hAAAA_0000; #1;
        check("mthi stall", stallreq, 1'b0);
        m_hi = 32'hAAAA_0000;
        @(negedge clk); op = LONG_OP; src1 = 32'hFFFF_FFFD; src2 = 32'd5; #1;
        check("mthi hi", hi_o, m_hi);
        check("flush accept stall", stallreq, 1'b1);
        repeat (11) @(negedge clk);
        #1;
        check("flush busy_before", busy, 1'b1);
        flush = 1'b1; start = 1'b0; #1;
        check("flush stall_in_cycle", stallreq, 1'b1);
        @(negedge clk); flush = 1'b0; #1;
        check("flush stall_after", stallreq, 1'b0);
        check("flush busy_after", busy, 1'b0);
        check("flush hi", hi_o, m_hi);
        check("flush lo", lo_o, m_lo);
        saw_done = 1'b0;
        repeat (40) begin @(negedge clk); #1; if (done) saw_done = 1'b1; end
        check("flush no_done", saw_done, 1'b0);
        check("flush hi_late", hi_o, m_hi);

        // back to normal after the flush
        run_op(OP_MULT, 32'd7, 32'hFFFF_FFFE, "post_flush");

        // reset mid-operation at cnt == 20
        @(negedge clk); start = 1'b1; op = LONG_OP; src1 = 32'd1000; src2 = 32'd3;
        repeat (21) @(negedge clk);
        #1;
        check("rst_mid busy_before", busy, 1'b1);
        rst = 1'b1; start = 1'b0; #1;
        check("rst_mid hi", hi_o, RST_VAL);
        check("rst_mid lo", lo_o, RST_VAL);
        check("rst_mid busy", busy, 1'b0);
        check("rst_mid stall", stallreq, 1'b0);
        m_hi = RST_VAL; m_lo = RST_VAL;
        #2 rst = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin @(negedge clk); #1; if (done) saw_done = 1'b1; end
        check("rst_mid no_done", saw_done, 1'b0);

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_again");
        check("sb drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
